// File: rtl/cache_refill_axi_pkg.sv
// Shared types and size helpers for the cache line refill engine.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned line_beats(input int unsigned lsb, input int unsigned dw);
    return (32'd1 << lsb) / (dw / 8);
  endfunction

endpackage

// File: rtl/cache_refill_axi_if.sv
// AXI4 read-address and read-data channels used by the refill engine.
interface cache_refill_axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/cache_refill_axi_watchdog.sv
// Refill watchdog: counts stalled cycles, any handshake restarts the count.
module refill_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_kick,
  output logic o_expire
);
  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || !i_active || i_kick) r_cnt <= '0;
    else if (r_cnt != W'(TIMEOUT))    r_cnt <= r_cnt + W'(1);
  end

  // Fires during the TIMEOUT-th consecutive stalled cycle.
  assign o_expire = i_active && !i_kick && (r_cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/cache_refill_axi.sv
// Cache line refill over one AXI4 INCR read burst, one word per cycle out.
// Optional watchdog enabled by defining REFILL_TIMEOUT_EN.
module cache_refill_axi
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LINE_SIZE_BITS = 7,
  parameter int unsigned REFILL_TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                miss,
  input  logic [ADDR_WIDTH-1:0]               cpu_addr,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_data_out,
  output logic [bytes_per_word(DATA_WIDTH)-1:0] mem_wstb,
  output logic                                mem_data_valid,
  output logic                                mem_last,
  cache_refill_axi_if.master                  axi,
  output logic                                refill_err,
  output logic                                busy
);
  localparam int unsigned BPW        = bytes_per_word(DATA_WIDTH);
  localparam int unsigned WORD_SHIFT = log2c(BPW);
  localparam int unsigned BEATS      = line_beats(LINE_SIZE_BITS, DATA_WIDTH);
  localparam int unsigned CNT_W      = LINE_SIZE_BITS - WORD_SHIFT + 1;

  refill_state_t         r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base, r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [BPW-1:0]        r_mem_wstb;
  logic                  r_mem_valid, r_mem_last, r_err;
  logic [CNT_W-1:0]      r_beat;
  logic                  w_ar_hs, w_r_hs, w_last_beat, w_beat_err, w_wd_expire;

  assign w_ar_hs     = axi.m_axi_arvalid && axi.m_axi_arready;
  assign w_r_hs      = axi.m_axi_rvalid && axi.m_axi_rready;
  assign w_last_beat = (r_beat == CNT_W'(BEATS - 1));
  assign w_beat_err  = (axi.m_axi_rresp != AXI_RESP_OKAY) || (axi.m_axi_rlast != w_last_beat);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (miss) w_next = ST_ADDR;
      ST_ADDR: if (w_ar_hs) w_next = ST_DATA;
      ST_DATA: if (w_r_hs && w_last_beat) w_next = ST_DONE;
      ST_DONE: if (!miss) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base      <= '0;
      r_beat      <= '0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_wstb  <= '0;
      r_mem_valid <= 1'b0;
      r_mem_last  <= 1'b0;
    end else begin
      r_mem_valid <= 1'b0;
      r_mem_last  <= 1'b0;
      if (r_state == ST_IDLE && miss) begin
        r_base <= {cpu_addr[ADDR_WIDTH-1:LINE_SIZE_BITS], {LINE_SIZE_BITS{1'b0}}};
        r_beat <= '0;
        r_err  <= 1'b0;
      end
      if (w_r_hs) begin
        r_mem_valid <= 1'b1;
        r_mem_data  <= axi.m_axi_rdata;
        r_mem_wstb  <= '1;
        r_mem_addr  <= r_base + (ADDR_WIDTH'(r_beat) << WORD_SHIFT);
        r_mem_last  <= w_last_beat;
        r_beat      <= r_beat + CNT_W'(1);
        if (w_beat_err) r_err <= 1'b1;
      end
      if (w_wd_expire) r_err <= 1'b1;
    end
  end

`ifdef REFILL_TIMEOUT_EN
  refill_watchdog #(.TIMEOUT(REFILL_TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_active (r_state == ST_ADDR || r_state == ST_DATA),
    .i_kick   (w_ar_hs || w_r_hs),
    .o_expire (w_wd_expire)
  );
`else
  assign w_wd_expire = 1'b0;
`endif

  assign axi.m_axi_arvalid = (r_state == ST_ADDR);
  assign axi.m_axi_araddr  = r_base;
  assign axi.m_axi_arlen   = 8'(BEATS - 1);
  assign axi.m_axi_arsize  = 3'(WORD_SHIFT);
  assign axi.m_axi_arburst = AXI_BURST_INCR;
  assign axi.m_axi_rready  = (r_state == ST_DATA);

  assign mem_addr       = r_mem_addr;
  assign mem_data_out   = r_mem_data;
  assign mem_wstb       = r_mem_wstb;
  assign mem_data_valid = r_mem_valid;
  assign mem_last       = r_mem_last;
  assign refill_err     = r_err;
  assign busy           = (r_state != ST_IDLE);
endmodule

// File: tb/tb_cache_refill_axi.sv
// Self-checking bench for cache_refill_axi with a word-list reference model.
module tb_cache_refill_axi;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        miss = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_wstb;
  logic        mem_data_valid, mem_last, refill_err, busy;

  cache_refill_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  cache_refill_axi #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE_BITS(7), .REFILL_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .miss(miss), .cpu_addr(cpu_addr),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_wstb(mem_wstb),
    .mem_data_valid(mem_data_valid), .mem_last(mem_last), .axi(axi),
    .refill_err(refill_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstb;
    logic        last;
    logic        err;
    int unsigned cyc;
  } word_t;

  word_t       got[$];
  word_t       exp_q[$];
  int unsigned cyc = 0;
  int unsigned ar_hs_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_data_valid) got.push_back('{mem_addr, mem_data_out, mem_wstb, mem_last, refill_err, cyc});
    if (axi.m_axi_arvalid && axi.m_axi_arready) ar_hs_cnt++;
  end

  initial begin
    axi.m_axi_arready = 1'b0;
    axi.m_axi_rvalid  = 1'b0;
    axi.m_axi_rdata   = '0;
    axi.m_axi_rresp   = 2'b00;
    axi.m_axi_rlast   = 1'b0;
  end

  // Drives one refill. mode: 0 back-to-back, 1 toggling rvalid, 2 random gaps.
  // stop_at < 32 asserts reset together with that beat and returns at once.
  task automatic do_refill(input logic [31:0] addr, input int ar_delay, input int mode,
                           input int resp_err_beat, input int rlast_bad_beat, input int stop_at);
    logic [31:0] base;
    int          n, b, guard, stable, hs0;
    bit          err, v;
    got.delete();
    exp_q.delete();
    hs0  = ar_hs_cnt;
    base = addr & 32'hFFFF_FF80;
    err  = 1'b0;
`ifdef REFILL_TIMEOUT_EN
    if (ar_delay >= 16) err = 1'b1;
`endif
    @(posedge clk); #1;
    miss = 1'b1;
    cpu_addr = addr;
    axi.m_axi_arready = 1'b0;
    n = 0;
    while (!axi.m_axi_arvalid && n < 20) begin @(posedge clk); #1; n++; end
    n_tests++;
    if (axi.m_axi_arvalid !== 1'b1 || refill_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start: arvalid=%b refill_err=%b, required 1 and 0", axi.m_axi_arvalid, refill_err);
    end
    stable = 0;
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      if (axi.m_axi_arvalid === 1'b1 && axi.m_axi_araddr === base && axi.m_axi_arlen === 8'd31 &&
          axi.m_axi_arsize === 3'd2 && axi.m_axi_arburst === 2'b01) stable++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (stable != ar_delay) begin
      n_fail++;
      $display("FAIL ar_stable: %0d stable stall cycles, required %0d", stable, ar_delay);
    end
    axi.m_axi_arready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({axi.m_axi_arvalid, axi.m_axi_araddr, axi.m_axi_arlen, axi.m_axi_arsize, axi.m_axi_arburst} !==
        {1'b1, base, 8'd31, 3'd2, 2'b01}) begin
      n_fail++;
      $display("FAIL ar_fields: valid=%b addr=%h len=%0d size=%0d burst=%0d, required 1 %h 31 2 1",
               axi.m_axi_arvalid, axi.m_axi_araddr, axi.m_axi_arlen, axi.m_axi_arsize,
               axi.m_axi_arburst, base);
    end
    @(posedge clk); #1;
    axi.m_axi_arready = 1'b0;
    b = 0;
    guard = 0;
    while (b < 32 && guard < 400) begin
      if (b == stop_at) begin
        reset = 1'b1;
        axi.m_axi_rvalid = 1'b1;
        axi.m_axi_rdata  = $urandom;
        @(posedge clk); #1;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      axi.m_axi_rvalid = v;
      if (v) begin
        axi.m_axi_rdata = (mode == 0) ? 32'(b) : $urandom;
        axi.m_axi_rresp = (b == resp_err_beat) ? 2'b10 : 2'b00;
        axi.m_axi_rlast = (b == 31) ^ (b == rlast_bad_beat);
        if (b == resp_err_beat || b == rlast_bad_beat) err = 1'b1;
        exp_q.push_back('{base + 32'(4 * b), axi.m_axi_rdata, 4'hF, (b == 31), err, cyc + 1});
        b++;
      end
      @(posedge clk); #1;
      guard++;
    end
    axi.m_axi_rvalid = 1'b0;
    axi.m_axi_rlast  = 1'b0;
    axi.m_axi_rresp  = 2'b00;
    if (stop_at >= 32) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || ar_hs_cnt - hs0 != 1 || refill_err !== err) begin
        n_fail++;
        $display("FAIL done_hold: busy=%b ar_handshakes=%0d refill_err=%b, required 1 1 %b",
                 busy, ar_hs_cnt - hs0, refill_err, err);
      end
      @(posedge clk); #1;
      miss = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_exit: busy=%b, required 0", busy);
      end
      n_tests++;
      if (got.size() != 32 || exp_q.size() != 32) begin
        n_fail++;
        $display("FAIL word_count: %0d words delivered, required 32 (model %0d)", got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        n_tests++;
        if ({got[i].addr, got[i].data, got[i].wstb, got[i].last, got[i].err} !==
            {exp_q[i].addr, exp_q[i].data, exp_q[i].wstb, exp_q[i].last, exp_q[i].err} ||
            got[i].cyc != exp_q[i].cyc) begin
          n_fail++;
          $display("FAIL word%0d: addr=%h data=%h wstb=%h last=%b err=%b cyc=%0d, required %h %h %h %b %b %0d",
                   i, got[i].addr, got[i].data, got[i].wstb, got[i].last, got[i].err, got[i].cyc,
                   exp_q[i].addr, exp_q[i].data, exp_q[i].wstb, exp_q[i].last, exp_q[i].err, exp_q[i].cyc);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if ({busy, axi.m_axi_arvalid, axi.m_axi_rready, mem_data_valid, mem_last, refill_err} !== 6'b0 ||
        mem_addr !== '0 || mem_data_out !== '0 || mem_wstb !== '0 || axi.m_axi_araddr !== '0) begin
      n_fail++;
      $display("FAIL %s: busy=%b arv=%b rrdy=%b mv=%b ml=%b err=%b ma=%h md=%h ws=%h ara=%h, required all zero",
               name, busy, axi.m_axi_arvalid, axi.m_axi_rready, mem_data_valid, mem_last, refill_err,
               mem_addr, mem_data_out, mem_wstb, axi.m_axi_araddr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_refill(32'h0000_1234, 0, 0, -1, -1, 99);
  endtask

  task automatic test_ar_stall();
    do_refill(32'h0000_8F00, 10, 0, -1, -1, 99);
  endtask

  task automatic test_rvalid_toggle();
    do_refill(32'hABCD_0040, 0, 1, -1, -1, 99);
  endtask

  task automatic test_rresp_err();
    do_refill(32'h0000_2000, 2, 0, 5, -1, 99);
    do_refill(32'h0000_2080, 0, 0, -1, -1, 99);
  endtask

  task automatic test_rlast_err();
    do_refill(32'h1000_0100, 0, 2, -1, 10, 99);
    do_refill(32'h1000_0200, 0, 0, -1, 31, 99);
  endtask

  task automatic test_reset_midburst();
    int hs0;
    do_refill(32'h0000_3300, 0, 0, -1, -1, 16);
    hs0 = ar_hs_cnt;
    @(negedge clk);
    check_reset_outputs("reset_midburst");
    reset = 1'b0;
    miss = 1'b0;
    axi.m_axi_rvalid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (got.size() != 16 || ar_hs_cnt != hs0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: %0d words, %0d new handshakes, busy=%b, required 16 0 0",
               got.size(), ar_hs_cnt - hs0, busy);
    end
    do_refill(32'h0000_3300, 1, 0, -1, -1, 99);
  endtask

  task automatic test_watchdog_stall();
    do_refill(32'h0000_4400, 20, 0, -1, -1, 99);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      do_refill($urandom, $urandom_range(0, 6), 2,
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31)) : -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1, 99);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_rvalid_toggle();
    test_rresp_err();
    test_rlast_err();
    test_reset_midburst();
    test_watchdog_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
